scoreboard: RTL
===============

# scoreboard

In-order dual-issue hazard tracker between the decoder and the operands stage. It allocates a scoreboard id (sid) to each issued instruction and tracks registers with pending writes. It drives the per-slot stall signals consumed by the operands stage. It marks entries complete on writeback and retires them in program order; a writeback flush clears all in-flight state.

## Interface
- `SB_W`, 3: log2 of entry count; `SB_SIZE = 2**SB_W` (8). sid width `SB_W+1`; the MSB is the wrap bit.
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous active-low reset`
- `flush_i  in  1  flush from wb; clears all entries and busy state`
- `instN_decoder_valid_i  in  1  slot N (N=0,1) holds an instruction`
- `instN_decoder_rsK_valid_i / instN_decoder_rsK_i  in  1 / 5  source K (K=1,2,3) used / address`
- `instN_decoder_rd_type_i  in  2  2'b00 = no destination, else writes rd`
- `instN_decoder_rd_i  in  5  destination address`
- `stall_operands_inst0_o, stall_operands_inst1_o  out  1  hold slot 0 / slot 1`
- `sb_alloc_sid0_o, sb_alloc_sid1_o  out  SB_W+1  sid assigned to slot 0 / slot 1 if issued this cycle`
- `instN_wb_valid_i / instN_wb_sid_i / instN_wb_rd_i  in  1 / SB_W+1 / 5  writeback completion, two ports`
- `sb_count_o  out  SB_W+1  occupied entries`
- `sb_empty_o  out  1  count == 0`

## Operation
- State:
  - Circular buffer `head`/`tail` (SB_W+1 bits each, wrap bit included).
  - Per entry: `valid`, `done`, `has_rd`, `rd`.
  - Per register: `busy` bit (32) and `owner` sid.
  - x0 is never busy.
- Hazard for slot N: any valid source K with `rsK != 0` and `busy[rsK]`.
- `stall0 = valid0 & (hazard0 | count == SB_SIZE)`.
- `stall1 = valid1 & (stall0 | hazard1 | intra | free < 1 + issue0)`:
  - `intra`: slot 0 writes a nonzero rd that equals any valid slot-1 source.
  - `issue0 = valid0 & !stall0`.
  - `free = SB_SIZE - count`.
  - Slot 1 never issues ahead of slot 0.
- Issue:
  - `issueN = validN & !stallN & !flush_i`.
  - Slot 0 takes sid `tail`. Slot 1 takes `tail + issue0`.
  - `sb_alloc_sid1_o = tail + (valid0 ? 1 : 0)`.
  - `tail` advances by `issue0 + issue1`.
  - Each issued entry writes `valid=1`, `done=0`, `has_rd = rd_type != 0 && rd != 0`.
  - If `has_rd`: set `busy[rd]=1` and `owner[rd]=sid`; a later writer replaces the owner (WAW).
- Writeback, per port when `wb_valid` and the entry at `sid[SB_W-1:0]` is valid:
  - Set `done`.
  - Clear `busy[wb_rd]` only if `owner[wb_rd] == wb_sid`.
  - Writebacks to invalid entries are ignored.
- Retire: `head` advances by 0, 1 or 2 per cycle over consecutive `valid & done` entries starting at `head`. Retired entries are cleared.
- Flush: `head`, `tail` and count go to 0; all `valid` and `busy` bits clear. Flush overrides same-cycle issue, writeback and retire.

## Timing
- Reset and flush state: all entries invalid, all busy clear, `head = tail = 0`.
- Output values after reset:
  - `sb_count_o = 0`, `sb_empty_o = 1`.
  - Stalls 0 unless hazard inputs present.
  - `sb_alloc_sid0_o = 0`, `sb_alloc_sid1_o = 0` or `1`.
- Stalls and alloc sids are combinational from registered state plus the current decoder inputs. Nothing else is combinational.
- Busy set is visible to the decoder one cycle after issue. Busy clear is visible one cycle after writeback; there is no same-cycle bypass, so a same-cycle writeback still stalls.
- Same cycle, issue sets `busy[r]` and writeback clears `busy[r]` for the old owner: the set wins and `owner` becomes the new sid.
- Both wb ports hitting the same register in one cycle: each clear is evaluated independently against `owner`.
- Count update: `count_next = count + issued - retired`, with both terms possible in the same cycle.
- Full (count = 8): slot 0 stalls. A retirement in the same cycle does not unblock issue until the next cycle.
- Pointer wrap: sid 7 to 8 flips the wrap bit. Entry index is the low SB_W bits.
- Reset asserted mid-operation clears everything asynchronously.

## Structure
- Shared package additions:
  - `SCOREBOARD_SIZE_WIDTH` (= SB_W) and `SB_SIZE`.
  - `RD_TYPE_NONE = 2'b00`.
  - The sid width macro already used by the decoder/operands sid ports.
- One natural sub-module, `sb_reg_busy`: the 32-entry busy/owner array, with 2 set ports (issue) and 2 owner-checked clear ports (wb), plus flush.
- Entry buffer, pointers, and stall logic stay in the top.

## Test plan
- Reset, then issue `add x5` (slot 0) and `add x6` (slot 1) with no sources:
  - `sb_alloc_sid0/1 = 0/1`, no stalls.
  - Next cycle `sb_count_o = 2`, `busy[5]` and `busy[6]` set.
- Intra-pair RAW: slot 0 writes x7 and slot 1 reads x7 → `stall_operands_inst1_o = 1`, `stall0 = 0`, count +1.
- Pending x5 (sid 0), slot 0 reads x5:
  - Stalls while busy.
  - wb `sid 0, rd 5` at cycle T → stall still 1 at T, 0 at T+1.
- WAW: sid 0 and sid 1 both write x9. wb sid 0 first → `busy[9]` stays 1. wb sid 1 → clears.
- Fill 8 entries:
  - Slot 0 stalls at count 8.
  - Complete sid 0 → retire at T+1, issue resumes at T+2 with sid 8 (wrap bit 1, index 0).
- Flush with 5 in-flight entries plus a same-cycle issue:
  - Next cycle count = 0, all busy clear, alloc sid0 = 0.
  - Later writebacks to old sids are ignored.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard constants, sid type and a source-hazard helper.
package scoreboard_pkg;

  localparam int unsigned SCOREBOARD_SIZE_WIDTH = 3;
  localparam int unsigned SB_SIZE               = 2 ** SCOREBOARD_SIZE_WIDTH;
  // sid carries one extra wrap bit above the entry index
  localparam int unsigned SID_W                 = SCOREBOARD_SIZE_WIDTH + 1;

  localparam logic [1:0] RD_TYPE_NONE = 2'b00;

  typedef logic [SID_W-1:0] sid_t;
  typedef logic [4:0]       reg_addr_t;

  // A used, nonzero source whose register has a pending write.
  function automatic logic src_hazard(input logic [31:0] busy, input logic vld,
                                      input reg_addr_t addr);
    return vld && (addr != 5'd0) && busy[addr];
  endfunction

endpackage

// File: rtl/scoreboard_sb_reg_busy.sv
// Per-register pending-write tracker: busy bit plus the sid of the youngest writer.
module sb_reg_busy
  import scoreboard_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        set0_valid_i,
  input  reg_addr_t   set0_rd_i,
  input  sid_t        set0_sid_i,
  input  logic        set1_valid_i,
  input  reg_addr_t   set1_rd_i,
  input  sid_t        set1_sid_i,
  input  logic        clr0_valid_i,
  input  reg_addr_t   clr0_rd_i,
  input  sid_t        clr0_sid_i,
  input  logic        clr1_valid_i,
  input  reg_addr_t   clr1_rd_i,
  input  sid_t        clr1_sid_i,
  output logic [31:0] busy_o
);

  logic [31:0]            busy_q, busy_d;
  logic [31:0][SID_W-1:0] owner_q, owner_d;

  // Clears are checked against the old owner; sets land after so a new writer wins.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (clr0_valid_i && (owner_q[clr0_rd_i] == clr0_sid_i)) busy_d[clr0_rd_i] = 1'b0;
    if (clr1_valid_i && (owner_q[clr1_rd_i] == clr1_sid_i)) busy_d[clr1_rd_i] = 1'b0;
    if (set0_valid_i) begin
      busy_d[set0_rd_i]  = 1'b1;
      owner_d[set0_rd_i] = set0_sid_i;
    end
    // slot 1 is younger, so it owns the register on a same-pair WAW
    if (set1_valid_i) begin
      busy_d[set1_rd_i]  = 1'b1;
      owner_d[set1_rd_i] = set1_sid_i;
    end
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy/owner state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/scoreboard.sv
// Dual-issue in-order hazard tracker: sid allocation, stalls, completion and retire.
module scoreboard
  import scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       inst0_decoder_valid_i,
  input  logic       inst0_decoder_rs1_valid_i,
  input  logic [4:0] inst0_decoder_rs1_i,
  input  logic       inst0_decoder_rs2_valid_i,
  input  logic [4:0] inst0_decoder_rs2_i,
  input  logic       inst0_decoder_rs3_valid_i,
  input  logic [4:0] inst0_decoder_rs3_i,
  input  logic [1:0] inst0_decoder_rd_type_i,
  input  logic [4:0] inst0_decoder_rd_i,
  input  logic       inst1_decoder_valid_i,
  input  logic       inst1_decoder_rs1_valid_i,
  input  logic [4:0] inst1_decoder_rs1_i,
  input  logic       inst1_decoder_rs2_valid_i,
  input  logic [4:0] inst1_decoder_rs2_i,
  input  logic       inst1_decoder_rs3_valid_i,
  input  logic [4:0] inst1_decoder_rs3_i,
  input  logic [1:0] inst1_decoder_rd_type_i,
  input  logic [4:0] inst1_decoder_rd_i,
  output logic       stall_operands_inst0_o,
  output logic       stall_operands_inst1_o,
  output logic [3:0] sb_alloc_sid0_o,
  output logic [3:0] sb_alloc_sid1_o,
  input  logic       inst0_wb_valid_i,
  input  logic [3:0] inst0_wb_sid_i,
  input  logic [4:0] inst0_wb_rd_i,
  input  logic       inst1_wb_valid_i,
  input  logic [3:0] inst1_wb_sid_i,
  input  logic [4:0] inst1_wb_rd_i,
  output logic [3:0] sb_count_o,
  output logic       sb_empty_o
);

  localparam int unsigned IdxW = SCOREBOARD_SIZE_WIDTH;
  typedef logic [IdxW-1:0] idx_t;

  sid_t                    head_q, head_d, tail_q, tail_d;
  logic [SB_SIZE-1:0]      valid_q, valid_d, done_q, done_d, has_rd_q, has_rd_d;
  logic [SB_SIZE-1:0][4:0] rd_q, rd_d;
  logic [31:0]             busy;

  sid_t count, free, sid1;
  logic full, hazard0, hazard1, has_rd0, has_rd1, intra;
  logic stall0, stall1, issue0_pre, issue0, issue1;
  logic wb0_hit, wb1_hit, retire0, retire1;
  idx_t head_idx, head_idx1, wb0_idx, wb1_idx;

  // Hazards, stalls and issue decisions from registered state and decoder inputs.
  always_comb begin
    count   = tail_q - head_q;
    free    = sid_t'(SB_SIZE) - count;
    full    = (count == sid_t'(SB_SIZE));
    hazard0 = src_hazard(busy, inst0_decoder_rs1_valid_i, inst0_decoder_rs1_i) ||
              src_hazard(busy, inst0_decoder_rs2_valid_i, inst0_decoder_rs2_i) ||
              src_hazard(busy, inst0_decoder_rs3_valid_i, inst0_decoder_rs3_i);
    hazard1 = src_hazard(busy, inst1_decoder_rs1_valid_i, inst1_decoder_rs1_i) ||
              src_hazard(busy, inst1_decoder_rs2_valid_i, inst1_decoder_rs2_i) ||
              src_hazard(busy, inst1_decoder_rs3_valid_i, inst1_decoder_rs3_i);
    has_rd0 = (inst0_decoder_rd_type_i != RD_TYPE_NONE) && (inst0_decoder_rd_i != 5'd0);
    has_rd1 = (inst1_decoder_rd_type_i != RD_TYPE_NONE) && (inst1_decoder_rd_i != 5'd0);
    // slot 1 reads what slot 0 is about to write
    intra   = inst0_decoder_valid_i && has_rd0 &&
              ((inst1_decoder_rs1_valid_i && (inst1_decoder_rs1_i == inst0_decoder_rd_i)) ||
               (inst1_decoder_rs2_valid_i && (inst1_decoder_rs2_i == inst0_decoder_rd_i)) ||
               (inst1_decoder_rs3_valid_i && (inst1_decoder_rs3_i == inst0_decoder_rd_i)));
    stall0     = inst0_decoder_valid_i && (hazard0 || full);
    issue0_pre = inst0_decoder_valid_i && !stall0;
    stall1     = inst1_decoder_valid_i &&
                 (stall0 || hazard1 || intra || (free < (sid_t'(1) + sid_t'(issue0_pre))));
    issue0     = issue0_pre && !flush_i;
    issue1     = inst1_decoder_valid_i && !stall1 && !flush_i;
    sid1       = tail_q + sid_t'(issue0);
  end

  // Writeback hits and in-order retire of up to two completed entries.
  always_comb begin
    wb0_idx   = inst0_wb_sid_i[IdxW-1:0];
    wb1_idx   = inst1_wb_sid_i[IdxW-1:0];
    wb0_hit   = inst0_wb_valid_i && valid_q[wb0_idx];
    wb1_hit   = inst1_wb_valid_i && valid_q[wb1_idx];
    head_idx  = head_q[IdxW-1:0];
    head_idx1 = head_idx + idx_t'(1);
    retire0   = valid_q[head_idx] && done_q[head_idx];
    retire1   = retire0 && valid_q[head_idx1] && done_q[head_idx1];
  end

  // Entry buffer and pointer next state; flush overrides everything.
  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    has_rd_d = has_rd_q;
    rd_d     = rd_q;
    if (wb0_hit) done_d[wb0_idx] = 1'b1;
    if (wb1_hit) done_d[wb1_idx] = 1'b1;
    if (retire0) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
    end
    if (retire1) begin
      valid_d[head_idx1] = 1'b0;
      done_d[head_idx1]  = 1'b0;
    end
    if (issue0) begin
      valid_d[tail_q[IdxW-1:0]]  = 1'b1;
      done_d[tail_q[IdxW-1:0]]   = 1'b0;
      has_rd_d[tail_q[IdxW-1:0]] = has_rd0;
      rd_d[tail_q[IdxW-1:0]]     = inst0_decoder_rd_i;
    end
    if (issue1) begin
      valid_d[sid1[IdxW-1:0]]  = 1'b1;
      done_d[sid1[IdxW-1:0]]   = 1'b0;
      has_rd_d[sid1[IdxW-1:0]] = has_rd1;
      rd_d[sid1[IdxW-1:0]]     = inst1_decoder_rd_i;
    end
    head_d = head_q + sid_t'(retire0) + sid_t'(retire1);
    tail_d = tail_q + sid_t'(issue0) + sid_t'(issue1);
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // Entry buffer and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      has_rd_q <= '0;
      rd_q     <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      has_rd_q <= has_rd_d;
      rd_q     <= rd_d;
    end
  end

  sb_reg_busy u_reg_busy (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush_i),
    .set0_valid_i (issue0 && has_rd0),
    .set0_rd_i    (inst0_decoder_rd_i),
    .set0_sid_i   (tail_q),
    .set1_valid_i (issue1 && has_rd1),
    .set1_rd_i    (inst1_decoder_rd_i),
    .set1_sid_i   (sid1),
    .clr0_valid_i (wb0_hit),
    .clr0_rd_i    (inst0_wb_rd_i),
    .clr0_sid_i   (inst0_wb_sid_i),
    .clr1_valid_i (wb1_hit),
    .clr1_rd_i    (inst1_wb_rd_i),
    .clr1_sid_i   (inst1_wb_sid_i),
    .busy_o       (busy)
  );

  assign stall_operands_inst0_o = stall0;
  assign stall_operands_inst1_o = stall1;
  assign sb_alloc_sid0_o        = tail_q;
  assign sb_alloc_sid1_o        = tail_q + sid_t'(inst0_decoder_valid_i);
  assign sb_count_o             = count;
  assign sb_empty_o             = (count == '0);

endmodule
